// File: rtl/wq_fetch_sched.sv
// -----------------------------------------------------------------------------
// wq_fetch_sched
//
// Fetch scheduler for the 40-entry wavefront instruction-queue pool. A
// round-robin arbiter picks the next wavefront allowed to fetch and presents it
// to the fetch unit on a valid/ready handshake. The block counts in-flight
// fetches, drives the pool's per-queue tail-increment and write strobes, and
// drops returns that belong to wavefronts flushed while their fetch was out.
//
// Parameters:
//   MAX_OUTSTANDING  cap on accepted-but-unreturned fetches (1..40)
//
// Ports:
//   clk              sole clock
//   rst              asynchronous, active-low reset
//   wf_active[40]    slot holds a live wavefront
//   stop_fetch[40]   per-queue back-pressure from the pool
//   wf_flush[40]     per-wavefront flush pulse (forwarded as q_reset)
//   fetch_valid      request presented to the fetch unit
//   fetch_wfid[6]    wavefront id of the presented request
//   fetch_ready      fetch unit accepts the presented request
//   fetch_ack        fetched instruction returning
//   fetch_ack_wfid   wavefront id of the returning fetch
//   q_vtail_incr[40] one-hot pulse, one cycle after each accepted fetch
//   q_wr[40]         one-hot pulse, one cycle after each kept return
//   q_reset[40]      registered copy of wf_flush
//   outstanding[6]   current in-flight fetch count
//
// Build option:
//   WQ_SCHED_PERF_EN  adds 32-bit counters perf_grants (accepts) and
//                     perf_stall (cycles a request was held back only by the
//                     outstanding cap while some wavefront wanted to fetch).
// -----------------------------------------------------------------------------
module wq_fetch_sched #(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] wf_active,
    input  logic [39:0] stop_fetch,
    input  logic [39:0] wf_flush,
    output logic        fetch_valid,
    output logic [5:0]  fetch_wfid,
    input  logic        fetch_ready,
    input  logic        fetch_ack,
    input  logic [5:0]  fetch_ack_wfid,
    output logic [39:0] q_vtail_incr,
    output logic [39:0] q_wr,
    output logic [39:0] q_reset,
    output logic [5:0]  outstanding
`ifdef WQ_SCHED_PERF_EN
    ,
    output logic [31:0] perf_grants,
    output logic [31:0] perf_stall
`endif
);

    localparam int NUM_WF = 40;

    // Registered state
    logic [39:0] pending_reg;
    logic [39:0] discard_reg;
    logic [5:0]  rr_ptr_reg;
    logic        fetch_valid_reg;
    logic [5:0]  fetch_wfid_reg;
    logic [39:0] q_vtail_incr_reg;
    logic [39:0] q_wr_reg;
    logic [39:0] q_reset_reg;
    logic [5:0]  outstanding_reg;

    // Next-state values
    logic [39:0] pending_next;
    logic [39:0] discard_next;
    logic [5:0]  rr_ptr_next;
    logic        fetch_valid_next;
    logic [5:0]  fetch_wfid_next;
    logic [39:0] q_vtail_incr_next;
    logic [39:0] q_wr_next;

    // Handshake and return decode
    logic        accept;
    logic        ack_valid;
    logic [39:0] presented_mask;
    logic [39:0] accept_mask;
    logic [39:0] ack_mask;
    logic [39:0] eligible;
    logic [6:0]  eff_count;
    logic        cap_ok;
    logic        slot_free;
    logic        load;
    logic        found;
    logic [5:0]  winner;

    assign accept = fetch_valid_reg & fetch_ready;

    // A return only counts when its wavefront really has a fetch in flight
    // (pending or discard). Anything else, including ids past the pool and
    // stale returns after a reset, is ignored.
    assign ack_valid = fetch_ack && (fetch_ack_wfid < 6'(NUM_WF)) &&
                       (pending_reg[fetch_ack_wfid] || discard_reg[fetch_ack_wfid]);

    assign presented_mask = fetch_valid_reg ? (40'd1 << fetch_wfid_reg) : 40'd0;
    assign accept_mask    = accept ? presented_mask : 40'd0;
    assign ack_mask       = ack_valid ? (40'd1 << fetch_ack_wfid) : 40'd0;

    // The presented wavefront is masked out so that accepting it cannot let
    // the arbiter pick it again before its pending bit is visible.
    assign eligible = wf_active & ~stop_fetch & ~pending_reg & ~discard_reg &
                      ~wf_flush & ~presented_mask;

    // In-flight count after this cycle's accept and return. The cap compares
    // against this value, so an accept this cycle uses a slot and an ack this
    // cycle frees one in time for the next request to load.
    assign eff_count = {1'b0, outstanding_reg} + {6'd0, accept} - {6'd0, ack_valid};
    assign cap_ok    = eff_count < 7'(MAX_OUTSTANDING);
    assign slot_free = ~fetch_valid_reg | accept;
    assign load      = slot_free & cap_ok & found;

    // Round-robin search starting at rr_ptr, wrapping 39 -> 0.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = 6'd0;
        idx    = 0;
        for (int k = 0; k < NUM_WF; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_WF) begin
                idx = idx - NUM_WF;
            end
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = 6'(idx);
            end
        end
    end

    // Per-wavefront bookkeeping. A flush turns an in-flight fetch (or one
    // accepted in the same cycle) into a discard; a return clears both bits.
    // A flush arriving with the return also suppresses the write strobe.
    generate
        for (genvar gi = 0; gi < NUM_WF; gi++) begin : g_wf
            assign pending_next[gi] = ~ack_mask[gi] & ~wf_flush[gi] &
                                      (pending_reg[gi] | accept_mask[gi]);
            assign discard_next[gi] = ~ack_mask[gi] &
                                      (discard_reg[gi] |
                                       (wf_flush[gi] & (pending_reg[gi] | accept_mask[gi])));
            assign q_wr_next[gi]         = ack_mask[gi] & ~discard_reg[gi] & ~wf_flush[gi];
            assign q_vtail_incr_next[gi] = accept_mask[gi] & ~wf_flush[gi];
        end
    endgenerate

    // Request slot: load the winner, otherwise empty on accept, otherwise
    // withdraw a held request whose wavefront is being flushed.
    always_comb begin
        fetch_valid_next = fetch_valid_reg;
        fetch_wfid_next  = fetch_wfid_reg;
        rr_ptr_next      = rr_ptr_reg;
        if (load) begin
            fetch_valid_next = 1'b1;
            fetch_wfid_next  = winner;
            rr_ptr_next      = (winner == 6'(NUM_WF - 1)) ? 6'd0 : winner + 6'd1;
        end else if (accept) begin
            fetch_valid_next = 1'b0;
        end else if (fetch_valid_reg && wf_flush[fetch_wfid_reg]) begin
            fetch_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_reg      <= '0;
            discard_reg      <= '0;
            rr_ptr_reg       <= '0;
            fetch_valid_reg  <= 1'b0;
            fetch_wfid_reg   <= '0;
            q_vtail_incr_reg <= '0;
            q_wr_reg         <= '0;
            q_reset_reg      <= '0;
            outstanding_reg  <= '0;
        end else begin
            pending_reg      <= pending_next;
            discard_reg      <= discard_next;
            rr_ptr_reg       <= rr_ptr_next;
            fetch_valid_reg  <= fetch_valid_next;
            fetch_wfid_reg   <= fetch_wfid_next;
            q_vtail_incr_reg <= q_vtail_incr_next;
            q_wr_reg         <= q_wr_next;
            q_reset_reg      <= wf_flush;
            outstanding_reg  <= eff_count[5:0];
        end
    end

    assign fetch_valid  = fetch_valid_reg;
    assign fetch_wfid   = fetch_wfid_reg;
    assign q_vtail_incr = q_vtail_incr_reg;
    assign q_wr         = q_wr_reg;
    assign q_reset      = q_reset_reg;
    assign outstanding  = outstanding_reg;

`ifdef WQ_SCHED_PERF_EN
    logic [31:0] perf_grants_reg;
    logic [31:0] perf_stall_reg;
    logic        stall_cap;

    // Some wavefront wants to fetch and the slot is free, yet the cap blocks it.
    assign stall_cap = (|(wf_active & ~stop_fetch)) & slot_free & ~cap_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_grants_reg <= '0;
            perf_stall_reg  <= '0;
        end else begin
            if (accept) begin
                perf_grants_reg <= perf_grants_reg + 32'd1;
            end
            if (stall_cap) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_grants = perf_grants_reg;
    assign perf_stall  = perf_stall_reg;
`endif

endmodule
